// File: rtl/act_pwl_if.sv
// Valid/ready stream bundle for the PLAN activation unit: one input
// channel (i_*) and one output channel (o_*).
interface act_pwl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] i_x;
    logic             i_mode;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_y;
    logic             o_valid;
    logic             o_ready;

    modport master (
        output i_x, i_mode, i_valid, o_ready,
        input  i_ready, o_y, o_valid
    );

    modport slave (
        input  i_x, i_mode, i_valid, o_ready,
        output i_ready, o_y, o_valid
    );
endinterface

// File: rtl/act_pwl.sv
// Three-stage piecewise-linear sigmoid/tanh unit with a global stall:
// pre-scale/abs, segment select, then symmetry fold and tanh rescale.
module act_pwl #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic      clk,
    input  logic      rst,
    act_pwl_if.slave  bus
);

    localparam int W1 = WIDTH + 1;

    localparam logic [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   ONE     = W1'(1)  << FRAC;
    localparam logic [WIDTH:0]   HALF    = W1'(1)  << (FRAC - 1);
    localparam logic [WIDTH:0]   TH_HI   = W1'(5)  << FRAC;
    localparam logic [WIDTH:0]   TH_MID  = W1'(19) << (FRAC - 3);
    localparam logic [WIDTH:0]   OFF_HI  = W1'(27) << (FRAC - 5);
    localparam logic [WIDTH:0]   OFF_MID = W1'(5)  << (FRAC - 3);

    logic adv;

    logic             v1_q;
    logic             neg1_q, neg1_d;
    logic             mode1_q;
    logic [WIDTH-1:0] a1_q, a1_d;

    logic             v2_q;
    logic             neg2_q;
    logic             mode2_q;
    logic [WIDTH:0]   s2_q, s2_d;

    logic             o_valid_q;
    logic [WIDTH-1:0] o_y_q, o_y_d;

    logic [WIDTH:0]   x2;
    logic [WIDTH-1:0] xs;
    logic [WIDTH:0]   ae;
    logic [WIDTH:0]   sig;

    // Every stage moves together; a held output freezes the whole pipe.
    assign adv         = ~o_valid_q | bus.o_ready;
    assign bus.i_ready = adv;
    assign bus.o_valid = o_valid_q;
    assign bus.o_y     = o_y_q;

    always_comb begin
        x2 = {bus.i_x, 1'b0};
        xs = bus.i_x;
        if (bus.i_mode) begin
            if (x2[WIDTH] != x2[WIDTH-1]) begin
                xs = x2[WIDTH] ? S_MIN : S_MAX;
            end else begin
                xs = x2[WIDTH-1:0];
            end
        end
        neg1_d = xs[WIDTH-1];
        a1_d   = xs;
        if (neg1_d) begin
            a1_d = (xs == S_MIN) ? S_MAX : -xs;
        end
    end

    always_comb begin
        ae = {1'b0, a1_q};
        if (ae >= TH_HI) begin
            s2_d = ONE;
        end else if (ae >= TH_MID) begin
            s2_d = (ae >> 5) + OFF_HI;
        end else if (ae >= ONE) begin
            s2_d = (ae >> 3) + OFF_MID;
        end else begin
            s2_d = (ae >> 2) + HALF;
        end
    end

    // tanh(x) = 2*sigmoid(2x) - 1; the final subtraction may wrap into the sign bit.
    always_comb begin
        sig   = neg2_q ? (ONE - s2_q) : s2_q;
        o_y_d = mode2_q ? WIDTH'((sig << 1) - ONE) : WIDTH'(sig);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            neg1_q    <= 1'b0;
            mode1_q   <= 1'b0;
            a1_q      <= '0;
            v2_q      <= 1'b0;
            neg2_q    <= 1'b0;
            mode2_q   <= 1'b0;
            s2_q      <= '0;
            o_valid_q <= 1'b0;
            o_y_q     <= '0;
        end else if (adv) begin
            v1_q      <= bus.i_valid;
            v2_q      <= v1_q;
            o_valid_q <= v2_q;
            if (bus.i_valid) begin
                neg1_q  <= neg1_d;
                mode1_q <= bus.i_mode;
                a1_q    <= a1_d;
            end
            if (v1_q) begin
                neg2_q  <= neg1_q;
                mode2_q <= mode1_q;
                s2_q    <= s2_d;
            end
            if (v2_q) begin
                o_y_q <= o_y_d;
            end
        end
    end

endmodule
